// File: rtl/udma_lin_ch_arbiter_if.sv
// Bus bundle between the uDMA linear channels and their shared L2 request port.
// Signal suffixes are relative to the arbiter: _i flows into it, _o flows out of it.
interface udma_lin_ch_arbiter_if #(
  parameter int N_CH   = 3,
  parameter int ADDR_W = 32,
  parameter int ID_W   = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic [N_CH-1:0]        ch_req_i;
  logic [N_CH-1:0]        ch_prio_i;
  logic [N_CH*ADDR_W-1:0] ch_addr_i;
  logic [N_CH*2-1:0]      ch_size_i;
  logic [N_CH-1:0]        ch_gnt_o;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [ADDR_W-1:0]      out_addr_o;
  logic [1:0]             out_size_o;
  logic [ID_W-1:0]        out_id_o;
  logic                   starve_o;

  // Arbiter side
  modport slave (
    input  ch_req_i, ch_prio_i, ch_addr_i, ch_size_i, out_ready_i,
    output ch_gnt_o, out_valid_o, out_addr_o, out_size_o, out_id_o, starve_o
  );

  // Channel / downstream side
  modport master (
    output ch_req_i, ch_prio_i, ch_addr_i, ch_size_i, out_ready_i,
    input  ch_gnt_o, out_valid_o, out_addr_o, out_size_o, out_id_o, starve_o
  );
endinterface

// File: rtl/udma_lin_ch_arbiter.sv
// uDMA linear-channel arbiter: merges N_CH transfer requests onto one registered
// L2 request port. Two priority classes, round-robin inside each class, and a
// starvation guard that promotes a waiting low-class request after STARVE_LIM
// consecutive high-class grants.
module udma_lin_ch_arbiter #(
  parameter int N_CH       = 3,
  parameter int ADDR_W     = 32,
  parameter int STARVE_LIM = 4,
  parameter int ID_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  udma_lin_ch_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);

  // First requester at or above ptr, wrapping; walking from the far end lets the
  // nearest requester overwrite earlier picks.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_CH-1:0] vec,
                                               input logic [ID_W-1:0] ptr);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    int              n;
    pick = {ID_W{1'b0}};
    for (int i = N_CH - 1; i >= 0; i--) begin
      n    = int'(ptr) + i;
      n    = (n >= N_CH) ? (n - N_CH) : n;
      idx  = ID_W'(n);
      pick = vec[idx] ? idx : pick;
    end
    return pick;
  endfunction

  // Pointer value following a grant to channel w.
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] w);
    int n;
    n = int'(w) + 1;
    return (n >= N_CH) ? {ID_W{1'b0}} : ID_W'(n);
  endfunction

  logic [N_CH-1:0]   h_s;
  logic [N_CH-1:0]   l_s;
  logic [N_CH-1:0]   gnt_s;
  logic              load_s;
  logic              grant_s;
  logic              promote_s;
  logic              use_l_s;
  logic              starve_s;
  logic [ID_W-1:0]   win_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [1:0]        sel_size_s;

  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic [1:0]        out_size_q,  out_size_d;
  logic [ID_W-1:0]   out_id_q,    out_id_d;
  logic [ID_W-1:0]   ptr_hi_q,    ptr_hi_d;
  logic [ID_W-1:0]   ptr_lo_q,    ptr_lo_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  // Class split, load condition, promotion and winner selection
  always_comb begin
    h_s       = bus.ch_req_i & bus.ch_prio_i;
    l_s       = bus.ch_req_i & ~bus.ch_prio_i;
    load_s    = ~out_valid_q | bus.out_ready_i;
    // No grant may escape while reset is asserted.
    grant_s   = load_s & (|bus.ch_req_i) & rstn_i;
    promote_s = (cnt_q == CNT_W'(STARVE_LIM)) & (|l_s);
    use_l_s   = (|l_s) & (~(|h_s) | promote_s);
    if (use_l_s) begin
      win_s = rr_pick(l_s, ptr_lo_q);
    end else begin
      win_s = rr_pick(h_s, ptr_hi_q);
    end
    gnt_s    = grant_s ? (N_CH'(1'b1) << win_s) : {N_CH{1'b0}};
    starve_s = grant_s & promote_s;
  end

  // Mux the winning channel's address and size
  always_comb begin
    sel_addr_s = {ADDR_W{1'b0}};
    sel_size_s = 2'b00;
    for (int k = 0; k < N_CH; k++) begin
      sel_addr_s = sel_addr_s | (bus.ch_addr_i[k*ADDR_W +: ADDR_W] & {ADDR_W{win_s == ID_W'(k)}});
      sel_size_s = sel_size_s | (bus.ch_size_i[k*2 +: 2] & {2{win_s == ID_W'(k)}});
    end
  end

  // Next-state for output register, class pointers and starvation counter
  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_size_d  = out_size_q;
    out_id_d    = out_id_q;
    ptr_hi_d    = ptr_hi_q;
    ptr_lo_d    = ptr_lo_q;
    cnt_d       = cnt_q;

    if (grant_s) begin
      out_valid_d = 1'b1;
      out_addr_d  = sel_addr_s;
      out_size_d  = sel_size_s;
      out_id_d    = win_s;
      if (use_l_s) begin
        ptr_lo_d = next_ptr(win_s);
      end else begin
        ptr_hi_d = next_ptr(win_s);
      end
    end else if (load_s) begin
      // Slot drained with nothing to refill it; data fields keep their value.
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    // Counts high-class grants that bypass a waiting low-class request.
    if (~(|l_s)) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (grant_s & use_l_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (grant_s) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output register update
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= {ADDR_W{1'b0}};
      out_size_q  <= 2'b00;
      out_id_q    <= {ID_W{1'b0}};
      ptr_hi_q    <= {ID_W{1'b0}};
      ptr_lo_q    <= {ID_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_size_q  <= out_size_d;
      out_id_q    <= out_id_d;
      ptr_hi_q    <= ptr_hi_d;
      ptr_lo_q    <= ptr_lo_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.ch_gnt_o    = gnt_s;
  assign bus.starve_o    = starve_s;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_addr_o  = out_addr_q;
  assign bus.out_size_o  = out_size_q;
  assign bus.out_id_o    = out_id_q;

endmodule

// File: doc/udma_lin_ch_arbiter.md
Name: udma_lin_ch_arbiter

Overview:
- Parametrised arbiter for the uDMA linear channels.
- Merges N_CH linear-channel transfer requests onto one shared L2 request port, one transfer per cycle.
- Arbitration: two priority classes, round-robin within each class, starvation guard for the low class.
- Instantiated once per direction (TX lin, RX lin); N_CH is the derived channel count for that direction.

Parameters:
- N_CH, 3: number of channels arbitrated, >= 1.
- ADDR_W, 32: transfer address width.
- STARVE_LIM, 4: consecutive high-class grants tolerated while a low-class request waits, >= 1.
- ID_W, (N_CH > 1 ? $clog2(N_CH) : 1): channel index width.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- ch_req_i  in  N_CH  per-channel request
- ch_prio_i  in  N_CH  1 = high class
- ch_addr_i  in  N_CH*ADDR_W  per-channel address; channel k at bits [k*ADDR_W +: ADDR_W]
- ch_size_i  in  N_CH*2  per-channel size: 00 byte, 01 half, 10 word, 11 passed through unchanged
- ch_gnt_o  out  N_CH  one-hot grant pulse
- out_valid_o  out  1  output register holds a transfer
- out_ready_i  in  1  downstream accepts
- out_addr_o  out  ADDR_W  granted address
- out_size_o  out  2  granted size
- out_id_o  out  ID_W  granted channel index
- starve_o  out  1  pulses in the cycle a promoted low-class grant is issued

Behaviour:
- Clock/reset: single clock clk_i; reset rstn_i is asynchronous and active-low.
- Reset values: out_valid_o=0, out_addr_o=0, out_size_o=0, out_id_o=0, ch_gnt_o=0, starve_o=0, both round-robin pointers=0, starvation counter=0.
- Request handshake:
  - Channel holds ch_req_i with stable addr/size/prio until its ch_gnt_o pulse.
  - Dropping a request before grant is allowed; it is then not granted.
- Capture condition: `load = ~out_valid_o | out_ready_i`. Arbitration only when load=1 and at least one ch_req_i is high.
- On a grant, in the same cycle:
  - ch_gnt_o[w] is pulsed.
  - Next edge: out_valid_o=1, out_addr_o/out_size_o/out_id_o = channel w's values.
  - Latency: request visible at cycle n -> out_valid_o at n+1.
  - Throughput: one transfer per cycle while out_ready_i=1.
- Output register when load=1 and no request: out_valid_o<=0; data fields hold their last value.
- Output register when out_valid_o=1 and out_ready_i=0: all output fields hold, ch_gnt_o=0.
- Class selection:
  - H = req & prio; L = req & ~prio.
  - Grant from H if H != 0, unless the promotion condition holds; otherwise grant from L.
- Round-robin within a class:
  - Search starts at that class's pointer p, upward with wrap N_CH-1 -> 0.
  - First requester wins.
  - After a grant to w in that class, that class's pointer <= (w+1) mod N_CH. The other class's pointer is unchanged.
- Starvation counter (width $clog2(STARVE_LIM+1)):
  - Increments on each H grant while L != 0.
  - Clears on any L grant, or on any cycle with L == 0.
  - Promotion: counter == STARVE_LIM and L != 0 -> the grant is taken from L even if H != 0, and starve_o pulses.
  - Counter never exceeds STARVE_LIM.
- N_CH == 1: arbitration degenerates to pass-through with the register stage; out_id_o=0.
- Simultaneous events:
  - A request arriving in the same cycle a grant issues to another channel waits for the next load cycle.
  - Same-channel back-to-back: req held high after its gnt is treated as a new request.
- Reset mid-operation: the pending output transfer is discarded, no grant is issued during reset, and the state returns to the reset values.
- A prio change while a request waits takes effect at the next arbitration.

Test Plan:
- N_CH=3, all low class, req=3'b111 held, out_ready_i=1 -> gnt sequence ch0, ch1, ch2, ch0; out_id_o=0,1,2,0 one cycle after each gnt.
- ch1 high, ch0 and ch2 low, all requesting continuously, STARVE_LIM=4 -> four ch1 grants, then a ch0 grant with starve_o=1, four ch1 grants, then a ch2 grant with starve_o=1.
- ch0 req with addr 0x1C000100, size 2'b10; out_ready_i=0 for 5 cycles -> out_valid_o=1 and fields stable for 5 cycles; ch0's second request is not granted until the cycle out_ready_i=1.
- Single request ch2 at cycle 10, no other traffic -> ch_gnt_o=3'b100 at cycle 10; out_valid_o=1, out_id_o=2 at cycle 11; out_valid_o=0 at cycle 12 with out_ready_i=1.
- Assert rstn_i low asynchronously while out_valid_o=1 and pointers nonzero -> out_valid_o=0 immediately; after release, req=3'b111 grants ch0 first.
- N_CH=1, req held, out_ready_i toggling 1,0,1 -> gnt only in cycles with load=1; out_id_o=0 throughout.
